// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, step-FSM states and bus-mux code helpers for controle_multiciclo.
package ctrl_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOP  = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_HALT} state_t;

    function automatic int mux_imm(input int rx_w);
        return 1 << rx_w;
    endfunction

    function automatic int mux_g(input int rx_w);
        return (1 << rx_w) + 1;
    endfunction
endpackage

// File: rtl/ctrl_onehot_dec.sv
// ctrl_onehot_dec: register address to one-hot write enable, forced to zero when i_en is low.
module ctrl_onehot_dec #(
    parameter int RX_W = 3
) (
    input  logic                 i_en,
    input  logic [RX_W-1:0]      i_rx,
    output logic [2**RX_W-1:0]   o_onehot
);
    localparam int NREGS = 2**RX_W;

    always_comb o_onehot = i_en ? (NREGS'(1'b1) << i_rx) : '0;
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle step FSM with run/done handshake driving the datapath enables.
// Optional macro CTRL_ILLEGAL_TRAP_EN makes opcode 011 halt with a sticky illegal flag.
module controle_multiciclo
    import ctrl_pkg::*;
#(
    parameter  int RX_W  = 3,
    localparam int NREGS = 2**RX_W,
    localparam int IW    = 3 + 2*RX_W,
    localparam int MUX_W = RX_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [IW-1:0]    iin,
    input  logic             alu_zero,
    output logic [MUX_W-1:0] mux_select,
    output logic [NREGS-1:0] regs_enable,
    output logic [1:0]       alu_op_select,
    output logic             reg_a_enable,
    output logic             alu_output_enable,
    output logic             out_enable,
    output logic             done,
    output logic             busy,
    output logic             illegal
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    state_t            r_state, w_next;
    logic [IW-1:0]     r_ir;
    logic [2:0]        w_op, w_new_op;
    logic [RX_W-1:0]   w_rx, w_ry;
    logic              w_wr;

    assign w_op     = r_ir[IW-1 -: 3];
    assign w_new_op = iin[IW-1 -: 3];
    assign w_rx     = r_ir[2*RX_W-1:RX_W];
    assign w_ry     = r_ir[RX_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (run && (r_state == S_IDLE || r_state == S_T3)) r_ir <= iin;
        end
    end

    always_comb begin
        w_next            = r_state;
        mux_select        = '0;
        w_wr              = 1'b0;
        reg_a_enable      = 1'b0;
        alu_output_enable = 1'b0;
        out_enable        = 1'b0;
        done              = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_T1: begin
                w_next       = S_T2;
                mux_select   = {1'b0, w_rx};
                reg_a_enable = 1'b1;
            end
            S_T2: begin
                w_next            = S_T3;
                mux_select        = {1'b0, w_ry};
                alu_output_enable = 1'b1;
            end
            S_T3: begin
                w_next     = S_IDLE;
                done       = 1'b1;
                out_enable = w_op == OP_OUT;
                mux_select = (w_op <= OP_NAND) ? MUX_W'(mux_g(RX_W)) :
                             (w_op == OP_LDI)  ? MUX_W'(mux_imm(RX_W)) :
                             (w_op == OP_OUT)  ? {1'b0, w_rx} :
                             (w_op == OP_NOP)  ? '0 : {1'b0, w_ry};
                w_wr       = w_op <= OP_NAND || w_op == OP_LDI || w_op == OP_MOV ||
                             (w_op == OP_MVNZ && !alu_zero);
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
        // accepting a new instruction overrides the default return from IDLE/T3
        if (run && (r_state == S_IDLE || r_state == S_T3))
            w_next = (w_new_op <= OP_NAND) ? S_T1 :
                     (TRAP && w_new_op == OP_NOP) ? S_HALT : S_T3;
    end

    assign alu_op_select = w_op[2] ? 2'b11 : w_op[1:0];
    assign busy          = r_state != S_IDLE;
    assign illegal       = TRAP && r_state == S_HALT;

    ctrl_onehot_dec #(.RX_W(RX_W)) u_dec (
        .i_en     (w_wr),
        .i_rx     (w_rx),
        .o_onehot (regs_enable)
    );
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: vector table, hand sequences and random run against a queue-based model.
module tb_controle_multiciclo;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] mux;
        logic [31:0] regs;
        logic [1:0]  aop;
        logic        a, g, o, d, b, il;
    } out_t;

    typedef struct {
        bit         run;
        logic [8:0] iin;
        bit         az;
        out_t       e;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        run3 = 1'b0, az3 = 1'b0;
    logic [8:0]  iin3 = '0;
    logic [3:0]  mux3;
    logic [7:0]  regs3;
    logic [1:0]  aop3;
    logic        a3, g3, o3, d3, b3, il3;

    logic        run4 = 1'b0, az4 = 1'b0;
    logic [10:0] iin4 = '0;
    logic [4:0]  mux4;
    logic [15:0] regs4;
    logic [1:0]  aop4;
    logic        a4, g4, o4, d4, b4, il4;

    controle_multiciclo #(.RX_W(3)) dut3 (
        .clock(clock), .reset(reset), .run(run3), .iin(iin3), .alu_zero(az3),
        .mux_select(mux3), .regs_enable(regs3), .alu_op_select(aop3),
        .reg_a_enable(a3), .alu_output_enable(g3), .out_enable(o3),
        .done(d3), .busy(b3), .illegal(il3)
    );

    controle_multiciclo #(.RX_W(4)) dut4 (
        .clock(clock), .reset(reset), .run(run4), .iin(iin4), .alu_zero(az4),
        .mux_select(mux4), .regs_enable(regs4), .alu_op_select(aop4),
        .reg_a_enable(a4), .alu_output_enable(g4), .out_enable(o4),
        .done(d4), .busy(b4), .illegal(il4)
    );

    int tests = 0, fails = 0;

    function automatic out_t mk(int mux, int regs, int aop, logic [5:0] f);
        return out_t'({32'(mux), 32'(regs), 2'(aop), f});
    endfunction

    function automatic out_t dut_out(bit sel);
        return sel ? out_t'({32'(mux4), 32'(regs4), aop4, a4, g4, o4, d4, b4, il4})
                   : out_t'({32'(mux3), 32'(regs3), aop3, a3, g3, o3, d3, b3, il3});
    endfunction

    task automatic check(input string nm, input bit sel, input out_t e);
        out_t act;
        act = dut_out(sel);
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (mux,regs,aop,a,g,out,done,busy,ill)", nm, act, e);
        end
    endtask

    // Expected outputs for one cycle of an instruction: phase 0 idle, 1 load A, 2 load G, 3 finish, 4 halted
    function automatic out_t model(int rxw, int ph, int ir, bit az);
        out_t e;
        int op, rx, ry, n;
        e  = '0;
        n  = 1 << rxw;
        op = (ir >> (2*rxw)) & 7;
        rx = (ir >> rxw) & (n - 1);
        ry = ir & (n - 1);
        e.aop = op < 4 ? 2'(op) : 2'b11;
        e.b   = ph != 0;
        e.il  = ph == 4;
        if (ph == 1) begin e.mux = 32'(rx); e.a = 1'b1; end
        if (ph == 2) begin e.mux = 32'(ry); e.g = 1'b1; end
        if (ph == 3) begin
            e.d = 1'b1;
            if (op < 3) begin e.mux = 32'(n + 1); e.regs = 32'(1 << rx); end
            else if (op == 5) begin e.mux = 32'(n); e.regs = 32'(1 << rx); end
            else if (op == 6 || op == 7) begin
                e.mux  = 32'(ry);
                e.regs = (op == 6 && az) ? 32'd0 : 32'(1 << rx);
            end
            else if (op == 4) begin e.mux = 32'(rx); e.o = 1'b1; end
        end
        return e;
    endfunction

    vec_t vecs[14];
    int   q[$];
    int   ir_m, ph;

    initial begin
        vecs[0]  = '{1'b1, 9'h00A, 1'b0, mk(0, 0,  0, 6'b000000)};
        vecs[1]  = '{1'b0, 9'h1FF, 1'b0, mk(1, 0,  0, 6'b100010)};
        vecs[2]  = '{1'b1, 9'h1FF, 1'b0, mk(2, 0,  0, 6'b010010)};
        vecs[3]  = '{1'b0, 9'h000, 1'b0, mk(9, 2,  0, 6'b000110)};
        vecs[4]  = '{1'b1, 9'h158, 1'b0, mk(0, 0,  0, 6'b000000)};
        vecs[5]  = '{1'b1, 9'h1E3, 1'b0, mk(8, 8,  3, 6'b000110)};
        vecs[6]  = '{1'b1, 9'h195, 1'b0, mk(3, 16, 3, 6'b000110)};
        vecs[7]  = '{1'b1, 9'h195, 1'b1, mk(5, 0,  3, 6'b000110)};
        vecs[8]  = '{1'b1, 9'h130, 1'b0, mk(5, 4,  3, 6'b000110)};
        vecs[9]  = '{1'b1, 9'h040, 1'b0, mk(6, 0,  3, 6'b001110)};
        vecs[10] = '{1'b1, 9'h1E3, 1'b0, mk(0, 0,  1, 6'b100010)};
        vecs[11] = '{1'b0, 9'h000, 1'b0, mk(0, 0,  1, 6'b010010)};
        vecs[12] = '{1'b0, 9'h000, 1'b0, mk(9, 1,  1, 6'b000110)};
        vecs[13] = '{1'b0, 9'h000, 1'b0, mk(0, 0,  1, 6'b000000)};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1 check("reset3", 0, mk(0, 0, 0, 6'b0));
        check("reset4", 1, mk(0, 0, 0, 6'b0));
        @(negedge clock);

        for (int i = 0; i < 14; i++) begin
            run3 = vecs[i].run; iin3 = vecs[i].iin; az3 = vecs[i].az;
            #1 check($sformatf("vec%0d", i), 0, vecs[i].e);
            @(negedge clock);
        end

        // reset sampled in T2 aborts the ADD
        run3 = 1'b1; iin3 = 9'h00A;
        @(negedge clock); run3 = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("abort%0d", i), 0, mk(0, 0, 0, 6'b0));
            @(negedge clock);
        end

        // RX_W=4: ADD R15,R0
        run4 = 1'b1; iin4 = 11'h0F0;
        @(negedge clock); run4 = 1'b0;
        #1 check("w4_t1", 1, mk(15, 0, 0, 6'b100010));
        @(negedge clock);
        #1 check("w4_t2", 1, mk(0, 0, 0, 6'b010010));
        @(negedge clock);
        #1 check("w4_t3", 1, mk(17, 16'h8000, 0, 6'b000110));
        @(negedge clock);

        // opcode 011
        run3 = 1'b1; iin3 = 9'h0C0;
        @(negedge clock);
        if (TRAP) begin
            iin3 = 9'h00A;
            for (int i = 0; i < 10; i++) begin
                #1 check($sformatf("halt%0d", i), 0, mk(0, 0, 3, 6'b000011));
                @(negedge clock);
            end
            run3 = 1'b0; reset = 1'b1;
            @(negedge clock); reset = 1'b0;
            #1 check("halt_cleared", 0, mk(0, 0, 0, 6'b0));
        end else begin
            run3 = 1'b0;
            #1 check("nop_t3", 0, mk(0, 0, 3, 6'b000110));
            @(negedge clock);
            #1 check("nop_idle", 0, mk(0, 0, 3, 6'b0));
        end
        @(negedge clock);

        reset = 1'b1;
        @(negedge clock);
        ir_m = 0;
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 63) == 0;
            run3  = 1'($urandom);
            iin3  = 9'($urandom);
            az3   = 1'($urandom);
            ph    = q.size() != 0 ? q[0] : 0;
            #1 check("rand", 0, model(3, ph, ir_m, az3));
            if (reset) begin
                q.delete();
                ir_m = 0;
            end else if ((ph == 0 || ph == 3) && run3) begin
                ir_m = int'(iin3);
                q.delete();
                if (iin3[8:6] < 3) begin q.push_back(1); q.push_back(2); q.push_back(3); end
                else if (TRAP && iin3[8:6] == 3) q.push_back(4);
                else q.push_back(3);
            end else if (ph != 4 && q.size() != 0) begin
                void'(q.pop_front());
            end
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Parametrised multi-cycle control unit for the processor datapath. It replaces the externally-stepped control logic with an internal step FSM, a run/done handshake and a register file whose size is set by parameter. It adds variable-latency instructions and a conditional move (MVNZ). It drives the register-file write enables, the A-register and G-register (ALU output) enables, the ALU op and the bus mux select.

Parameters:
RX_W, 3, register-address width; register count NREGS = 2**RX_W
IW, 3+2*RX_W, instruction width {opcode[2:0], rx, ry}; derived, not overridable
MUX_W, RX_W+1, bus mux select width; codes 0..NREGS-1 select a register, NREGS selects IMM, NREGS+1 selects G

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high
run  input  1  request to start an instruction; sampled in IDLE or T3
iin  input  IW  instruction word, captured when run is accepted
alu_zero  input  1  zero flag of the G register (MVNZ condition)
mux_select  output  MUX_W  bus source select
regs_enable  output  NREGS  one-hot register write enable
alu_op_select  output  2  00 ADD, 01 SUB, 10 NAND, 11 pass/none
reg_a_enable  output  1  load A register
alu_output_enable  output  1  load G register
out_enable  output  1  OUT strobe; bus carries rx
done  output  1  instruction completes this cycle
busy  output  1  state != IDLE
illegal  output  1  sticky trap flag (see Optional Feature); tied 0 otherwise

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high.
- Opcodes (3 bits): 000 ADD, 001 SUB, 010 NAND, 011 NOP/reserved, 100 OUT, 101 LDI, 110 MVNZ, 111 MOV.
- States: IDLE, T1, T2, T3. Outputs are Moore, decoded from state and the IR, except MVNZ's regs_enable (see T3).
- Reset values: state=IDLE, IR=0, mux_select=0, regs_enable=0, reg_a_enable=0, alu_output_enable=0, out_enable=0, done=0, busy=0, illegal=0.
- Reset mid-instruction aborts it. No enable is asserted in the cycle after reset is sampled.
- Accept: in IDLE with run=1, iin is latched into the IR. Next state is T1 for opcodes 000–010 and T3 for all others.
- IDLE with run=0: remain in IDLE; all enables 0.
- T1: mux_select={0,rx}, reg_a_enable=1. Next state T2.
- T2: mux_select={0,ry}, alu_output_enable=1. Next state T3.
- alu_op_select = IR.opcode[1:0] if IR.opcode[2]==0, else 2'b11. It is valid in every state.
- T3, by opcode:
  - ALU ops: mux_select=NREGS+1, regs_enable=onehot(rx).
  - MOV: mux_select={0,ry}, regs_enable=onehot(rx).
  - LDI: mux_select=NREGS, regs_enable=onehot(rx).
  - MVNZ: mux_select={0,ry}; regs_enable=onehot(rx) only if alu_zero==0, else 0. alu_zero is sampled combinationally in T3.
  - OUT: mux_select={0,rx}, out_enable=1, regs_enable=0.
  - NOP: no enables asserted.
- done=1 in every T3.
- Back-to-back: run=1 in T3 latches the new iin into the IR at the end of T3, with no IDLE bubble. Otherwise T3 returns to IDLE.
- Latency from the accept cycle: ALU ops reach done 3 cycles later; all other opcodes reach done 1 cycle later.
- run is ignored in T1 and T2. iin may change freely after the accept cycle.
- Register 0 is writable; there is no hardwired zero.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN.
- Defined: accepting opcode 011 goes to a HALT state. In HALT, illegal=1, busy=1, done never asserts, all enables are 0 and run is ignored. Only reset leaves HALT.
- Undefined: 011 executes as NOP (IDLE→T3, done=1), and illegal is constant 0.

Decomposition:
- Package ctrl_pkg: opcode localparams, state encoding enum, and functions for the mux codes (mux_imm(RX_W)=NREGS, mux_g(RX_W)=NREGS+1).
- Sub-module ctrl_onehot_dec (parameter RX_W): combinational rx→one-hot NREGS decoder, with an enable input gating the outputs to 0.

Test Plan:
1. RX_W=3. Reset, then run=1 with iin=000_001_010 (ADD R1,R2).
   - T1: mux_select=0001, reg_a_enable=1.
   - T2: mux_select=0010, alu_output_enable=1, alu_op_select=00.
   - T3: mux_select=1001, regs_enable=8'h02, done=1. Then IDLE.
2. iin=101_011_000 (LDI R3): T3 one cycle after accept, with mux_select=1000 and regs_enable=8'h08. Then run=1 in T3 with iin=111_100_011 (MOV R4,R3): the next cycle is T3 with mux_select=0011 and regs_enable=8'h10, with no IDLE gap.
3. iin=110_010_101 (MVNZ R2,R5):
   - alu_zero=1 → regs_enable=0, done=1.
   - Repeat with alu_zero=0 → regs_enable=8'h04.
4. iin=100_110_000 (OUT R6): T3 has out_enable=1, mux_select=0110, regs_enable=0. Then iin=001_000_000 (SUB): alu_op_select=01 in T2.
5. Start an ADD, then assert reset in T2. Next cycle: state IDLE, every enable 0, done never asserts. Then RX_W=4 run of ADD R15,R0: regs_enable=16'h8000, mux_select=10001 in T3.
6. iin=011_000_000:
   - Without the macro: done=1 in T3, no enables.
   - With CTRL_ILLEGAL_TRAP_EN: illegal=1 and busy=1 persist for 10 cycles with run=1, until reset clears them.
